keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_decoder.sv | 12 +
 rtl/keypad_scanner.sv | 107 ++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state enum, the key map and the row decoding helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        S_SCAN  = 2'd0,
        S_PRESS = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] IDLE_ROWS = 4'b1111;

    // Nibble {row,col} holds the hex label of that key; row 0 is the lowest 16 bits.
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    // Returns {single_row_low, row_index}; anything other than one low row is not a key.
    function automatic logic [2:0] decode_rows(input logic [3:0] r);
        case (r)
            4'b1110: return {1'b1, 2'd0};
            4'b1101: return {1'b1, 2'd1};
            4'b1011: return {1'b1, 2'd2};
            4'b0111: return {1'b1, 2'd3};
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Combinational key lookup: (row index, column index) -> hex key code.
module keypad_decoder
    import keypad_pkg::*;
(
    input  logic [1:0] row,
    input  logic [1:0] col,
    output logic [3:0] key_code
);

    assign key_code = KEY_MAP[{row, col, 2'b00} +: 4];

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad controller with single-press reporting.
// Define KEYPAD_SYNC_EN to insert a two-flop synchronizer on the row inputs.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter logic [23:0] SCAN_DIV = 24'd48000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid
);

    logic [3:0] rows_fsm;

`ifdef KEYPAD_SYNC_EN
    logic [3:0] rows_meta;
    logic [3:0] rows_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            rows_meta <= IDLE_ROWS;
            rows_sync <= IDLE_ROWS;
        end else begin
            rows_meta <= rows;
            rows_sync <= rows_meta;
        end
    end

    assign rows_fsm = rows_sync;
`else
    assign rows_fsm = rows;
`endif

    state_t      state;
    state_t      state_next;
    logic [1:0]  col_idx;
    logic [1:0]  col_next;
    logic [23:0] count;
    logic [23:0] count_next;
    logic        load_code;
    logic        row_hit;
    logic [1:0]  row_idx;
    logic [3:0]  decoded;

    assign {row_hit, row_idx} = decode_rows(rows_fsm);

    keypad_decoder u_decoder (
        .row      (row_idx),
        .col      (col_idx),
        .key_code (decoded)
    );

    always_comb begin
        state_next = state;
        col_next   = col_idx;
        count_next = count;
        load_code  = 1'b0;
        case (state)
            S_SCAN: begin
                if (count == SCAN_DIV - 24'd1) begin
                    count_next = '0;
                    if (row_hit) begin
                        state_next = S_PRESS;
                        load_code  = 1'b1;
                    end else begin
                        col_next = col_idx + 2'd1;
                    end
                end else begin
                    count_next = count + 24'd1;
                end
            end
            S_PRESS: state_next = S_HOLD;
            S_HOLD: begin
                // The column stays parked on the held key until every row is released.
                if (rows_fsm == IDLE_ROWS) begin
                    col_next   = col_idx + 2'd1;
                    count_next = '0;
                    state_next = S_SCAN;
                end
            end
            default: state_next = S_SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_SCAN;
            col_idx  <= 2'd0;
            count    <= '0;
            key_code <= 4'h0;
        end else begin
            state   <= state_next;
            col_idx <= col_next;
            count   <= count_next;
            if (load_code) begin
                key_code <= decoded;
            end
        end
    end

    assign cols      = ~(4'b0001 << col_idx);
    assign key_valid = (state == S_PRESS) && !reset;

endmodule
